// File: rtl/renkon_serial_ctrl_if.sv
// rtl/renkon_serial_ctrl_if.sv - control, core stream, drain stream and buffer port bundle of renkon_serial_ctrl
interface renkon_serial_ctrl_if #(
    parameter int DWIDTH  = 16,
    parameter int OUTSIZE = 8
);
    logic                      fill_start;
    logic                      drain_start;
    logic        [OUTSIZE-1:0] cfg_words;
    logic                      in_valid;
    logic signed [DWIDTH-1:0]  in_data;
    logic                      in_ready;
    logic                      out_valid;
    logic signed [DWIDTH-1:0]  out_data;
    logic                      out_ready;
    logic                      mem_we;
    logic        [OUTSIZE-1:0] mem_addr;
    logic signed [DWIDTH-1:0]  write_data;
    logic signed [DWIDTH-1:0]  read_data;
    logic                      fill_done;
    logic                      drain_done;
    logic                      busy;

    // master: the controller, which owns the buffer and both streams
    modport master (
        input  fill_start, drain_start, cfg_words, in_valid, in_data, out_ready, read_data,
        output in_ready, out_valid, out_data, mem_we, mem_addr, write_data,
        output fill_done, drain_done, busy
    );

    modport slave (
        output fill_start, drain_start, cfg_words, in_valid, in_data, out_ready, read_data,
        input  in_ready, out_valid, out_data, mem_we, mem_addr, write_data,
        input  fill_done, drain_done, busy
    );
endinterface

// File: rtl/renkon_serial_ctrl.sv
// rtl/renkon_serial_ctrl.sv - fill/drain sequencer for the single-port serial output buffer
module renkon_serial_ctrl #(
    parameter int DWIDTH  = 16,
    parameter int OUTSIZE = 8,
    parameter int WORDS   = 150
) (
    input  logic                  clk,
    input  logic                  xrst,
    renkon_serial_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FULL,
        S_PRIME,
        S_DRAIN
    } state_t;

    localparam logic [OUTSIZE-1:0] WORDS_L = OUTSIZE'(WORDS);

    state_t             state_q, state_d;
    logic [OUTSIZE-1:0] count_q, count_d;
    logic [OUTSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [OUTSIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic               fill_done_q, fill_done_d;
    logic               drain_done_q, drain_done_d;

    logic [OUTSIZE-1:0] clamped;
    logic [OUTSIZE-1:0] last_idx;
    logic               fill_hs;
    logic               drain_hs;

    assign clamped  = (bus.cfg_words > WORDS_L) ? WORDS_L : bus.cfg_words;
    assign last_idx = count_q - 1'b1;
    assign fill_hs  = (state_q == S_FILL) && bus.in_valid;
    assign drain_hs = (state_q == S_DRAIN) && bus.out_ready;

    assign bus.in_ready   = (state_q == S_FILL);
    assign bus.mem_we     = fill_hs;
    assign bus.write_data = (state_q == S_FILL) ? bus.in_data : '0;
    assign bus.out_valid  = (state_q == S_DRAIN);
    assign bus.out_data   = (state_q == S_DRAIN) ? bus.read_data : '0;
    assign bus.fill_done  = fill_done_q;
    assign bus.drain_done = drain_done_q;
    assign bus.busy       = (state_q == S_FILL) || (state_q == S_PRIME) || (state_q == S_DRAIN);

    // Read address is registered by the buffer, so stepping it on the handshake keeps data back-to-back
    always_comb begin
        bus.mem_addr = '0;
        case (state_q)
            S_FILL:  bus.mem_addr = wr_ptr_q;
            S_DRAIN: bus.mem_addr = drain_hs ? rd_ptr_q + 1'b1 : rd_ptr_q;
            default: bus.mem_addr = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_done_d  = 1'b0;
        drain_done_d = 1'b0;
        case (state_q)
            S_IDLE, S_FULL: begin
                if (bus.fill_start) begin
                    count_d  = clamped;
                    wr_ptr_d = '0;
                    if (clamped == '0) begin
                        state_d     = S_FULL;
                        fill_done_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                    end
                end else if (bus.drain_start && (state_q == S_FULL)) begin
                    state_d = S_PRIME;
                end
            end
            S_FILL: begin
                if (bus.in_valid) begin
                    if (wr_ptr_q == last_idx) begin
                        state_d     = S_FULL;
                        fill_done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            S_PRIME: begin
                rd_ptr_d = '0;
                if (count_q == '0) begin
                    state_d      = S_IDLE;
                    drain_done_d = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_ptr_q == last_idx) begin
                        state_d      = S_IDLE;
                        drain_done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_done_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_done_q  <= fill_done_d;
            drain_done_q <= drain_done_d;
        end
    end
endmodule

// File: tb/tb_renkon_serial_ctrl.sv
// tb/tb_renkon_serial_ctrl.sv - randomized scoreboard bench for renkon_serial_ctrl with a behavioural buffer
module tb_renkon_serial_ctrl;
    localparam int DW    = 16;
    localparam int OS    = 8;
    localparam int WORDS = 150;

    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    renkon_serial_ctrl_if #(.DWIDTH(DW), .OUTSIZE(OS)) bus ();

    renkon_serial_ctrl #(.DWIDTH(DW), .OUTSIZE(OS), .WORDS(WORDS)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    // Single-port buffer with registered read address; contents survive reset
    logic [DW-1:0] mem [0:255];
    logic [OS-1:0] rd_addr_q;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.write_data;
        rd_addr_q <= bus.mem_addr;
    end
    assign bus.read_data = mem[rd_addr_q];

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_out[$];
    logic [DW-1:0] ref_buf [0:WORDS-1];
    int            ref_count;
    logic [DW-1:0] fixed_data [0:3];

    int            n_checks;
    int            n_errors;
    int            hs_cnt;
    int            valid_cycles;
    int            fill_done_cnt;
    int            drain_done_cnt;
    bit            stall_pending;
    logic [DW-1:0] stall_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp_v, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!xrst) begin
            stall_pending = 1'b0;
        end else begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'(bus.mem_we), 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("write_addr", 32'(bus.mem_addr), 32'(w.addr));
                    chk("write_data", {16'b0, bus.write_data}, {16'b0, w.data});
                end
            end
            if (bus.out_valid) begin
                valid_cycles++;
                if (stall_pending) chk("stall_hold", {16'b0, bus.out_data}, {16'b0, stall_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                stall_pending = 1'b0;
                if (exp_out.size() == 0) begin
                    chk("unexpected_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_out.pop_front();
                    chk("drain_data", {16'b0, bus.out_data}, {16'b0, e});
                end
            end else if (bus.out_valid) begin
                stall_pending = 1'b1;
                stall_data    = bus.out_data;
            end else begin
                stall_pending = 1'b0;
            end
            if (bus.fill_done)  fill_done_cnt++;
            if (bus.drain_done) drain_done_cnt++;
        end
    end

    function automatic bit rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic do_fill(input int cfg, input bit fixed);
        int            n;
        int            base_fd;
        int            tries;
        bit            acc;
        logic [DW-1:0] d;
        n       = (cfg > WORDS) ? WORDS : cfg;
        base_fd = fill_done_cnt;
        bus.cfg_words  = OS'(cfg);
        bus.fill_start = 1'b1;
        @(posedge clk); #1;
        bus.fill_start = 1'b0;
        ref_count = n;
        if (n > 0) begin
            @(negedge clk); #1;
            chk("fill_busy", 32'(bus.busy), 32'd1);
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            d = fixed ? fixed_data[i] : DW'($urandom);
            ref_buf[i] = d;
            exp_wr.push_back('{addr: i, data: d});
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            tries = 0;
            do begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk); #1;
                tries++;
            end while (!acc && tries < 8);
            if (!acc) chk("fill_accept", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("fill_done_count", 32'(fill_done_cnt - base_fd), 32'd1);
        chk("fill_writes_left", 32'(exp_wr.size()), 32'd0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_busy", 32'(bus.busy), 32'd0);
        chk("full_addr", 32'(bus.mem_addr), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_drain(input int mode);
        int n;
        int base_hs;
        int base_vc;
        int base_dd;
        int k;
        int cyc;
        n       = ref_count;
        base_hs = hs_cnt;
        base_vc = valid_cycles;
        base_dd = drain_done_cnt;
        k       = 0;
        for (int i = 0; i < n; i++) exp_out.push_back(ref_buf[i]);
        bus.drain_start = 1'b1;
        bus.out_ready   = rdy(mode, 0);
        @(posedge clk); #1;
        bus.drain_start = 1'b0;
        if (n > 0) begin
            @(negedge clk); #1;
            chk("prime_valid", 32'(bus.out_valid), 32'd0);
            chk("prime_addr", 32'(bus.mem_addr), 32'd0);
            chk("prime_busy", 32'(bus.busy), 32'd1);
            @(negedge clk); #1;
            chk("drain_latency", 32'(bus.out_valid), 32'd1);
        end
        cyc = 0;
        while (drain_done_cnt == base_dd && cyc < n * 8 + 20) begin
            @(posedge clk); #1;
            k++;
            bus.out_ready = rdy(mode, k);
            @(negedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("drain_done_count", 32'(drain_done_cnt - base_dd), 32'd1);
        chk("drain_handshakes", 32'(hs_cnt - base_hs), 32'(n));
        if (mode == 0) chk("drain_throughput", 32'(valid_cycles - base_vc), 32'(n));
        chk("drain_words_left", 32'(exp_out.size()), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
        chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
        chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
        chk({tag, "_write_data"}, {16'b0, bus.write_data}, 32'd0);
        chk({tag, "_fill_done"},  32'(bus.fill_done),  32'd0);
        chk({tag, "_drain_done"}, 32'(bus.drain_done), 32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_hs;
        int base_vc;
        int base_dd;
        int cyc;
        fixed_data[0] = 16'd10;
        fixed_data[1] = 16'hFFFD;
        fixed_data[2] = 16'd7;
        fixed_data[3] = 16'd100;
        n_checks = 0; n_errors = 0; hs_cnt = 0; valid_cycles = 0;
        fill_done_cnt = 0; drain_done_cnt = 0; ref_count = 0;
        xrst = 1'b0;
        bus.fill_start = 1'b0; bus.drain_start = 1'b0; bus.cfg_words = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        @(posedge clk); #1;
        xrst = 1'b1;
        @(posedge clk); #1;

        do_fill(4, 1'b1);
        do_drain(0);
        do_fill(4, 1'b1);
        do_drain(1);

        do_fill(6, 1'b0);
        do_fill(3, 1'b0);
        do_drain(2);

        do_fill(200, 1'b0);
        do_drain(2);

        do_fill(0, 1'b0);
        do_drain(0);

        for (int r = 0; r < 3; r++) begin
            do_fill($urandom_range(1, 20), 1'b0);
            do_drain(r);
        end

        do_fill(5, 1'b0);
        for (int i = 0; i < ref_count; i++) exp_out.push_back(ref_buf[i]);
        base_hs = hs_cnt;
        bus.out_ready   = 1'b1;
        bus.drain_start = 1'b1;
        @(posedge clk); #1;
        bus.drain_start = 1'b0;
        cyc = 0;
        while (hs_cnt - base_hs < 2 && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        xrst = 1'b0;
        exp_out.delete();
        bus.out_ready = 1'b0;
        chk("reset_mid_hs", 32'(hs_cnt - base_hs), 32'd2);
        @(negedge clk); #1;
        chk_quiet("mid_reset");
        @(posedge clk); #1;
        xrst = 1'b1;
        ref_count = 0;

        base_vc = valid_cycles;
        base_dd = drain_done_cnt;
        bus.out_ready   = 1'b1;
        bus.drain_start = 1'b1;
        @(posedge clk); #1;
        bus.drain_start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("ignored_drain_valid", 32'(valid_cycles - base_vc), 32'd0);
        chk("ignored_drain_done", 32'(drain_done_cnt - base_dd), 32'd0);
        chk("ignored_drain_busy", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;

        do_fill(3, 1'b0);
        do_drain(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/renkon_serial_ctrl.md
Name: renkon_serial_ctrl

Overview:
- Sequencer and owner of the single-port serial output buffer: the word memory with registered read address, so read data follows the address by one cycle.
- FILL phase: accepts a stream of output words from the renkon core and writes them to addresses 0..N-1.
- DRAIN phase: replays the N words to the ninjin side on a valid/ready stream with backpressure.
- Only this block drives the buffer; core-side writes and host-side reads are mutually exclusive by construction.

Parameters:
- DWIDTH, 16, data word width.
- OUTSIZE, 8, buffer address width.
- WORDS, 150, buffer depth; cfg_words is clamped to this.

Ports:
- clk  in  1  clock.
- xrst  in  1  asynchronous active-low reset.
- fill_start  in  1  one-cycle pulse; latch cfg_words and begin FILL.
- drain_start  in  1  one-cycle pulse; begin DRAIN of the latched count.
- cfg_words  in  OUTSIZE  number of words for this pass.
- in_valid  in  1  core word valid.
- in_data  in  DWIDTH  signed core word.
- in_ready  out  1  controller accepts in_data.
- out_valid  out  1  drained word valid.
- out_data  out  DWIDTH  signed drained word.
- out_ready  in  1  downstream accepts out_data.
- mem_we  out  1  buffer write enable.
- mem_addr  out  OUTSIZE  buffer address.
- write_data  out  DWIDTH  buffer write data.
- read_data  in  DWIDTH  buffer read data, for the address presented on the previous edge.
- fill_done  out  1  one-cycle pulse when FILL completes.
- drain_done  out  1  one-cycle pulse when DRAIN completes.
- busy  out  1  high in any state except IDLE and FULL.

Behaviour:
- Reset values: state IDLE, count 0, wr_ptr 0, rd_ptr 0. All outputs 0: in_ready, out_valid, mem_we, mem_addr, write_data, fill_done, drain_done, busy.
- States and transitions:
  - IDLE -> FILL on fill_start.
  - FILL -> FULL after the last write.
  - FULL -> PRIME on drain_start.
  - PRIME -> DRAIN after one cycle.
  - DRAIN -> IDLE after the last handshake.
  - FULL -> FILL on fill_start; this overwrites the buffer and discards the previous pass.
- Start pulses in any other state are ignored.
- fill_start and drain_start in the same cycle: fill_start wins in IDLE and FULL.
- On fill_start, count <= min(cfg_words, WORDS) and wr_ptr <= 0.
  - If count is 0: go straight to FULL and pulse fill_done the next cycle, with no writes.
- FILL:
  - in_ready = 1.
  - On in_valid: mem_we = 1, mem_addr = wr_ptr, write_data = in_data; all combinational, same cycle.
  - wr_ptr then increments.
  - When the write at wr_ptr = count-1 occurs: next state FULL, fill_done pulses in the following cycle, in_ready drops.
- in_ready is 0 in every state except FILL. mem_we is 0 outside FILL handshakes.
- PRIME:
  - mem_addr = 0, rd_ptr <= 0.
  - If count is 0: go directly to IDLE with a drain_done pulse.
- DRAIN:
  - out_valid = 1 and out_data = read_data, which is the word at rd_ptr because the address was registered on the previous edge.
  - Handshake is out_valid & out_ready.
  - mem_addr = rd_ptr + 1 on a handshake, else rd_ptr. Holding the address keeps read_data stable under backpressure.
  - On a handshake at rd_ptr = count-1: next state IDLE, drain_done pulses in the next cycle, out_valid drops.
- Throughput: one word per cycle in both phases with continuous valid/ready.
- Drain latency: the first out_valid appears 2 cycles after drain_start.
- mem_addr is 0 in IDLE and FULL. Pointers never exceed count-1, so there is no wrap-around.
- Buffer contents persist across reset; the latched count does not.
- Reset mid-operation returns to IDLE immediately and discards the pass in progress.

Test Plan:
- Reset -> all outputs 0, busy 0, in_ready 0.
- fill_start with cfg_words=4, then in_data 10,-3,7,100 with in_valid gaps -> writes to addresses 0..3 with matching data. fill_done pulses once and in_ready drops.
- drain_start after that fill, out_ready tied high -> out_valid 2 cycles after drain_start, out_data 10,-3,7,100 on consecutive cycles, then drain_done.
- Drain with out_ready toggling 1,0,0,1,... -> out_data held constant while stalled, no word lost or repeated, exactly 4 handshakes.
- cfg_words=200 with WORDS=150 -> exactly 150 writes (addresses 0..149) and 150 drained words. cfg_words=0 -> fill_done and drain_done with no mem_we and no out_valid.
- xrst asserted mid-DRAIN after 2 words, then released -> state IDLE. drain_start is ignored until a new fill completes. A fresh fill of 3 words drains correctly.
